gen_rand_range_gen: RTL and testbench

Sequential random-number source that produces uniformly stepped pseudo-random values reduced into the range [0, z-1] on request. A Galois LFSR is advanced on each accepted request, the low DATA_W bits are registered, and an internal gen_pseudo_modulus_x_mod_z reduces them against the latched range bound z. The result is a registered value with a one-cycle valid pulse. The block sits directly upstream of the GA selection/crossover stages, which consume o_rand as population or bit indices.

---
 rtl/gen_pkg.sv | 18 +
 rtl/gen_pseudo_modulus_x_mod_z.sv | 45 ++++
 rtl/gen_rand_range_gen.sv | 132 +++++++++++++
 tb/tb_gen_rand_range_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/gen_pkg.sv
// Shared definitions for the pseudo-random generators feeding the GA stages.
package gen_pkg;

  // Request sequencing states of the range-reduced random source
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_MOD  = 2'd2
  } gen_state_e;

  localparam int unsigned LFSR_W_DEF = 16;

  // x^16 + x^14 + x^13 + x^11 + 1, Galois form
  localparam logic [LFSR_W_DEF-1:0] LFSR_TAPS_DEF     = 16'hB400;
  // Reset seed, also substituted whenever an all-zero seed is loaded
  localparam logic [LFSR_W_DEF-1:0] LFSR_DEF_SEED_DEF = 16'hACE1;

endpackage : gen_pkg

// File: rtl/gen_pseudo_modulus_x_mod_z.sv
// Cheap range reduction of x into [0, z-1]: mask x down to the smallest
// all-ones field covering z-1, then fold the overshoot back with one subtract.
// Purely combinational; the caller registers the result.
module gen_pseudo_modulus_x_mod_z
  import gen_pkg::*;
#(
  parameter int unsigned DATA_W = 11
) (
  input  logic              i_valid_pls,
  input  logic [DATA_W-1:0] i_x,
  input  logic [DATA_W-1:0] i_z,
  output logic [DATA_W-1:0] o_res_c,
  output logic              o_res_valid_pls
);

  logic [DATA_W-1:0] zm1_c;
  logic [DATA_W-1:0] mask_c;
  logic [DATA_W-1:0] masked_c;

  // Bit-smear z-1 so every bit at or below its MSB is set
  always_comb begin
    zm1_c  = i_z - DATA_W'(1);
    mask_c = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      mask_c[i] = |(zm1_c >> i);
    end
  end

  // Mask, compare against z and subtract once; z==0 is forced to zero
  always_comb begin
    masked_c = i_x & mask_c;
    o_res_c  = masked_c;
    if (i_z == '0) begin
      o_res_c = '0;
    end else if (masked_c >= i_z) begin
      o_res_c = masked_c - i_z;
    end
  end

  // Result qualifier passes straight through alongside the data
  always_comb begin
    o_res_valid_pls = i_valid_pls;
  end

endmodule : gen_pseudo_modulus_x_mod_z

// File: rtl/gen_rand_range_gen.sv
// On-request pseudo-random value in [0, z-1]: Galois LFSR step on accept,
// capture of the low bits, then range reduction into a held result with a
// one-cycle valid pulse. Latency 2 clocks, one result per 3 cycles at best.
module gen_rand_range_gen
  import gen_pkg::*;
#(
  parameter int unsigned       DATA_W        = 11,
  parameter int unsigned       LFSR_W        = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS     = LFSR_W'(LFSR_TAPS_DEF),
  parameter logic [LFSR_W-1:0] LFSR_DEF_SEED = LFSR_W'(LFSR_DEF_SEED_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_seed_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_req_pls,
  input  logic [DATA_W-1:0] i_z,
  output logic              o_busy,
  output logic              o_valid_pls,
  output logic [DATA_W-1:0] o_rand
);

  gen_state_e state_q;
  gen_state_e state_d;

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] x_d;
  logic [DATA_W-1:0] z_q;
  logic [DATA_W-1:0] z_d;
  logic [DATA_W-1:0] rand_q;
  logic [DATA_W-1:0] rand_d;
  logic              valid_q;
  logic              valid_d;
  logic              busy_q;
  logic              busy_d;

  logic              req_acc_c;
  logic              mod_en_c;
  logic [LFSR_W-1:0] lfsr_adv_c;
  logic [LFSR_W-1:0] seed_eff_c;
  logic [DATA_W-1:0] mod_res_c;
  logic              mod_vld_c;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a seed load both blocks a new request and aborts one in flight
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_req_pls && !i_seed_load) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        state_d = i_seed_load ? ST_IDLE : ST_MOD;
      end
      ST_MOD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM-derived controls and next values of the datapath registers
  always_comb begin
    req_acc_c  = (state_q == ST_IDLE) && i_req_pls && !i_seed_load;
    mod_en_c   = (state_q == ST_MOD) && !i_seed_load;
    lfsr_adv_c = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    seed_eff_c = (i_seed == '0) ? LFSR_DEF_SEED : i_seed;

    lfsr_d = lfsr_q;
    if (i_seed_load) begin
      lfsr_d = seed_eff_c;
    end else if (req_acc_c) begin
      lfsr_d = lfsr_adv_c;
    end

    z_d = req_acc_c ? i_z : z_q;
    x_d = ((state_q == ST_STEP) && !i_seed_load) ? lfsr_q[DATA_W-1:0] : x_q;

    rand_d  = mod_vld_c ? mod_res_c : rand_q;
    valid_d = mod_vld_c;
    busy_d  = (state_d != ST_IDLE);
  end

  // Range reduction between the x/z registers and the result register
  gen_pseudo_modulus_x_mod_z #(
    .DATA_W (DATA_W)
  ) u_pseudo_mod (
    .i_valid_pls     (mod_en_c),
    .i_x             (x_q),
    .i_z             (z_q),
    .o_res_c         (mod_res_c),
    .o_res_valid_pls (mod_vld_c)
  );

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q  <= LFSR_DEF_SEED;
      x_q     <= '0;
      z_q     <= '0;
      rand_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      x_q     <= x_d;
      z_q     <= z_d;
      rand_q  <= rand_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_valid_pls = valid_q;
  assign o_rand      = rand_q;

endmodule : gen_rand_range_gen

// File: tb/tb_gen_rand_range_gen.sv
// Self-checking bench for gen_rand_range_gen against a behavioural model.
module tb_gen_rand_range_gen;

  localparam int unsigned DW = 11;
  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_seed_load = 1'b0;
  logic [LW-1:0] i_seed = '0;
  logic          i_req_pls = 1'b0;
  logic [DW-1:0] i_z = '0;
  logic          o_busy;
  logic          o_valid_pls;
  logic [DW-1:0] o_rand;

  int errors = 0;
  int checks = 0;

  logic [LW-1:0] m_lfsr;
  logic [DW-1:0] m_rand;

  gen_rand_range_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_seed_load (i_seed_load),
    .i_seed      (i_seed),
    .i_req_pls   (i_req_pls),
    .i_z         (i_z),
    .o_busy      (o_busy),
    .o_valid_pls (o_valid_pls),
    .o_rand      (o_rand)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] ref_step(input logic [LW-1:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reduce x into [0,z-1]: keep x modulo the smallest power of two >= z,
  // then subtract z once if still out of range
  function automatic int unsigned ref_mod(input int unsigned x, input int unsigned z);
    int unsigned span;
    int unsigned m;
    if (z == 0) return 0;
    span = 1;
    while (span < z) span = span * 2;
    m = x % span;
    return (m >= z) ? m - z : m;
  endfunction

  function automatic logic [LW-1:0] ref_seed(input logic [LW-1:0] s);
    return (s == '0) ? 16'hACE1 : s;
  endfunction

  // Issue a request at the current negedge, expect the result two clocks later.
  // Returns at the negedge where o_valid_pls is high.
  task automatic req_check(input logic [DW-1:0] z, input string tag);
    int cyc;
    i_req_pls = 1'b1;
    i_z       = z;
    @(negedge clk);
    i_req_pls = 1'b0;
    i_z       = DW'($urandom);
    chk({tag, "_busy"}, 32'(o_busy), 32'd1);
    chk({tag, "_vld_lo"}, 32'(o_valid_pls), 32'd0);
    m_lfsr = ref_step(m_lfsr);
    m_rand = DW'(ref_mod(int'(m_lfsr[DW-1:0]), int'(z)));
    cyc = 0;
    while (o_valid_pls !== 1'b1 && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'd2);
    chk({tag, "_rand"}, 32'(o_rand), 32'(m_rand));
    chk({tag, "_busy_end"}, 32'(o_busy), 32'd0);
  endtask

  task automatic seed_load(input logic [LW-1:0] s);
    i_seed_load = 1'b1;
    i_seed      = s;
    @(negedge clk);
    i_seed_load = 1'b0;
    m_lfsr      = ref_seed(s);
  endtask

  task automatic count_valid(input int n, output int nv, output logic [DW-1:0] last);
    nv   = 0;
    last = '0;
    for (int k = 0; k < n; k++) begin
      if (o_valid_pls === 1'b1) begin
        nv++;
        last = o_rand;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int nv;
    logic [DW-1:0] got;
    logic [DW-1:0] z;
    logic [LW-1:0] s;

    repeat (3) @(negedge clk);
    chk("rst_rand", 32'(o_rand), 32'd0);
    chk("rst_valid", 32'(o_valid_pls), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    rst_n  = 1'b1;
    m_lfsr = 16'hACE1;
    m_rand = '0;
    @(negedge clk);

    // Golden sequence from reset, second request back-to-back with the pulse
    req_check(11'd100, "r1");
    chk("r1_golden", 32'(o_rand), 32'd12);
    req_check(11'd100, "r2");
    chk("r2_golden", 32'(o_rand), 32'd56);

    // Zero seed restarts the default sequence
    @(negedge clk);
    seed_load('0);
    req_check(11'd100, "seed0");
    chk("seed0_golden", 32'(o_rand), 32'd12);

    // Degenerate ranges
    @(negedge clk);
    req_check(11'd0, "z0");
    chk("z0_zero", 32'(o_rand), 32'd0);
    req_check(11'd1, "z1");
    chk("z1_zero", 32'(o_rand), 32'd0);

    // Requests while busy are dropped without advancing the LFSR
    @(negedge clk);
    m_lfsr = ref_step(m_lfsr);
    m_rand = DW'(ref_mod(int'(m_lfsr[DW-1:0]), 500));
    i_req_pls = 1'b1;
    i_z = 11'd500;
    repeat (3) @(negedge clk);
    i_req_pls = 1'b0;
    count_valid(6, nv, got);
    chk("busy_drop_pulses", 32'(nv), 32'd1);
    chk("busy_drop_rand", 32'(got), 32'(m_rand));
    req_check(11'd300, "after_busy");

    // Seed load during STEP aborts the request
    @(negedge clk);
    i_req_pls = 1'b1;
    i_z = 11'd200;
    @(negedge clk);
    i_req_pls = 1'b0;
    seed_load(16'h1234);
    count_valid(5, nv, got);
    chk("abort_step_pulses", 32'(nv), 32'd0);
    chk("abort_step_rand", 32'(o_rand), 32'(m_rand));
    chk("abort_step_busy", 32'(o_busy), 32'd0);
    req_check(11'd200, "post_step_abort");

    // Seed load during MOD aborts the request
    @(negedge clk);
    i_req_pls = 1'b1;
    i_z = 11'd77;
    @(negedge clk);
    i_req_pls = 1'b0;
    @(negedge clk);
    seed_load(16'h0BEE);
    count_valid(5, nv, got);
    chk("abort_mod_pulses", 32'(nv), 32'd0);
    chk("abort_mod_rand", 32'(o_rand), 32'(m_rand));
    req_check(11'd1000, "post_mod_abort");

    // Reset during MOD
    @(negedge clk);
    i_req_pls = 1'b1;
    i_z = 11'd1500;
    @(negedge clk);
    i_req_pls = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mod_valid", 32'(o_valid_pls), 32'd0);
    chk("rst_mod_busy", 32'(o_busy), 32'd0);
    chk("rst_mod_rand", 32'(o_rand), 32'd0);
    @(negedge clk);
    chk("rst_mod_valid2", 32'(o_valid_pls), 32'd0);
    rst_n  = 1'b1;
    m_lfsr = 16'hACE1;
    m_rand = '0;
    @(negedge clk);
    req_check(11'd100, "post_rst");
    chk("post_rst_golden", 32'(o_rand), 32'd12);

    // Random ranges, seeds and gaps
    for (int i = 0; i < 400; i++) begin
      z = DW'($urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        s = ($urandom_range(0, 3) == 0) ? '0 : LW'($urandom);
        @(negedge clk);
        seed_load(s);
      end
      req_check(z, "rnd");
      if (z > 1) chk("rnd_range", 32'(o_rand < z), 32'd1);
    end

    // Upper bound 2047 over many requests
    for (int i = 0; i < 10000; i++) begin
      req_check(11'd2047, "max");
      chk("max_range", 32'(o_rand < 11'd2047), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_gen_rand_range_gen
